// File: rtl/conv_pkg.sv
// conv_pkg: geometry helpers and FSM state encoding shared by the conv and pooling layers.
`default_nettype none

package conv_pkg;

  localparam int         STATE_W = 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_POOL  = 2'd1;
  localparam logic [1:0] S_FIN   = 2'd2;

  // Number of window positions along one axis; trailing partial windows are dropped.
  function automatic int pool_dim(input int size, input int pool, input int stride);
    return (size - pool) / stride + 1;
  endfunction

  function automatic int flat_idx(input int a, input int b, input int c,
                                  input int nb, input int nc);
    return a * nb * nc + b * nc + c;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/max_tree.sv
// max_tree: combinational signed max of N packed elements; clamps each element at 0 when RELU_EN is defined.
`default_nettype none

module max_tree #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic [N*WIDTH-1:0] elems,
  output logic [WIDTH-1:0]   max_out
);

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] x);
`ifdef RELU_EN
    return x[WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  logic [WIDTH-1:0] cand;

  always_comb begin
    max_out = clamp(elems[WIDTH-1:0]);
    cand    = '0;
    for (int k = 1; k < N; k++) begin
      cand = clamp(elems[k*WIDTH +: WIDTH]);
      if ($signed(cand) > $signed(max_out))
        max_out = cand;
    end
  end

endmodule

`default_nettype wire

// File: rtl/relu_maxpool.sv
// relu_maxpool: snapshots the conv feature map and max-pools one window per enabled clock.
// Optional ReLU clamp before pooling is enabled by defining RELU_EN.
`default_nettype none

module relu_maxpool
  import conv_pkg::*;
#(
  parameter int OUT_WIDTH   = 8,
  parameter int DEPTH       = 2,
  parameter int COL_SIZE    = 4,
  parameter int ROW_SIZE    = 4,
  parameter int POOL        = 2,
  parameter int POOL_STRIDE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic start,
  input  logic [DEPTH*ROW_SIZE*COL_SIZE*OUT_WIDTH-1:0] y_in,
  output logic [DEPTH*pool_dim(ROW_SIZE, POOL, POOL_STRIDE)*pool_dim(COL_SIZE, POOL, POOL_STRIDE)*OUT_WIDTH-1:0] p,
  output logic done
);

  localparam int PCOL  = pool_dim(COL_SIZE, POOL, POOL_STRIDE);
  localparam int PROW  = pool_dim(ROW_SIZE, POOL, POOL_STRIDE);
  localparam int WIN_N = POOL * POOL;
  localparam int DW    = cnt_w(DEPTH);
  localparam int IW    = cnt_w(PROW);
  localparam int JW    = cnt_w(PCOL);
  localparam logic [DW-1:0] D_LAST = DW'(DEPTH - 1);
  localparam logic [IW-1:0] I_LAST = IW'(PROW - 1);
  localparam logic [JW-1:0] J_LAST = JW'(PCOL - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [DW-1:0]      win_d;
  logic [IW-1:0]      win_i;
  logic [JW-1:0]      win_j;
  logic [$bits(y_in)-1:0] snap;
  logic               last_win, load, write, done_nxt;
  logic [WIN_N*OUT_WIDTH-1:0] win_elems;
  logic [OUT_WIDTH-1:0]       win_max;

  assign last_win = (win_d == D_LAST) && (win_i == I_LAST) && (win_j == J_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else if (en)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_POOL;
      S_POOL:  if (last_win) state_nxt = S_FIN;
      S_FIN:   if (!start)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    write    = 1'b0;
    done_nxt = 1'b0;
    case (state)
      S_IDLE: load = start;
      S_POOL: begin
        write    = 1'b1;
        done_nxt = last_win;
      end
      S_FIN:  done_nxt = start;
      default: ;
    endcase
  end

  // Gather the current window out of the snapshot, row-major inside the window.
  always_comb begin
    win_elems = '0;
    for (int a = 0; a < POOL; a++) begin
      for (int b = 0; b < POOL; b++) begin
        win_elems[(a*POOL+b)*OUT_WIDTH +: OUT_WIDTH] =
          snap[flat_idx(int'(win_d), int'(win_i)*POOL_STRIDE + a,
                        int'(win_j)*POOL_STRIDE + b, ROW_SIZE, COL_SIZE)*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  max_tree #(
    .WIDTH(OUT_WIDTH),
    .N    (WIN_N)
  ) u_max_tree (
    .elems  (win_elems),
    .max_out(win_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      snap  <= '0;
      p     <= '0;
      done  <= 1'b0;
      win_d <= '0;
      win_i <= '0;
      win_j <= '0;
    end else if (en) begin
      done <= done_nxt;
      if (load) begin
        snap  <= y_in;
        win_d <= '0;
        win_i <= '0;
        win_j <= '0;
      end
      if (write) begin
        p[flat_idx(int'(win_d), int'(win_i), int'(win_j), PROW, PCOL)*OUT_WIDTH +: OUT_WIDTH] <= win_max;
        if (win_j != J_LAST) begin
          win_j <= win_j + 1'b1;
        end else begin
          win_j <= '0;
          if (win_i != I_LAST) begin
            win_i <= win_i + 1'b1;
          end else begin
            win_i <= '0;
            win_d <= (win_d == D_LAST) ? '0 : win_d + 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: directed table plus random vectors against a loop-based pooling model.
`default_nettype none

module tb_relu_maxpool;

  logic         clk = 1'b0;
  logic         rst, en, start, done;
  logic [255:0] y_in;
  logic [63:0]  p;
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  relu_maxpool dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .start(start),
    .y_in (y_in),
    .p    (p),
    .done (done)
  );

  typedef struct {
    string        name;
    logic [255:0] y;
    logic [63:0]  exp;
  } vec_t;

  vec_t tbl[3];

  // 2 slices of 4x4, 2x2 windows, stride 2 -> 2x2 pooled per slice.
  function automatic logic [63:0] ref_pool(input logic [255:0] y);
    logic [63:0] r;
    byte         v;
    byte         best;
    r = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          best = -128;
          for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) begin
              v = y[(d*16 + (2*i+a)*4 + (2*j+b))*8 +: 8];
`ifdef RELU_EN
              if (v < 0) v = 0;
`endif
              if (v > best) best = v;
            end
          r[(d*4 + i*2 + j)*8 +: 8] = best;
        end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input string name, input logic [255:0] y, input logic [63:0] exp);
    int edges;
    edges = 0;
    y_in  = y;
    start = 1'b1;
    do begin
      step();
      edges++;
    end while (!done && edges < 30);
    chk({name, " latency"}, 64'(edges), 64'd9);
    chk({name, " p"}, p, exp);
    y_in = ~y;
    step();
    chk({name, " done held"}, {63'd0, done}, 64'd1);
    chk({name, " p held"}, p, exp);
    start = 1'b0;
    step();
    chk({name, " done drop"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [255:0] ramp, neg5, spot, r1, r2;
    logic [63:0]  e_neg5;
    int           edges;

    for (int k = 0; k < 32; k++) begin
      ramp[k*8 +: 8] = 8'(k);
      neg5[k*8 +: 8] = 8'hFB;
    end
    spot = '0;
    spot[28*8 +: 8] = 8'h7F;
`ifdef RELU_EN
    e_neg5 = 64'h0;
`else
    e_neg5 = 64'hFBFBFBFBFBFBFBFB;
`endif
    tbl[0] = '{"ramp", ramp, 64'h1F1D17150F0D0705};
    tbl[1] = '{"neg5", neg5, e_neg5};
    tbl[2] = '{"spot", spot, 64'h007F000000000000};

    // Reset must win even with en low.
    rst = 1'b1; en = 1'b0; start = 1'b0; y_in = ramp;
    step();
    chk("reset p", p, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    rst = 1'b0; en = 1'b1;
    step();

    for (int t = 0; t < 3; t++)
      run(tbl[t].name, tbl[t].y, tbl[t].exp);

    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 8; k++) r1[k*32 +: 32] = $urandom();
      run("random", r1, ref_pool(r1));
    end

    // Enable freeze mid-POOL delays done by exactly the frozen cycles.
    for (int k = 0; k < 8; k++) r1[k*32 +: 32] = $urandom();
    y_in = r1; start = 1'b1; edges = 0;
    repeat (3) begin step(); edges++; end
    en = 1'b0;
    repeat (3) begin step(); edges++; end
    chk("freeze done low", {63'd0, done}, 64'd0);
    en = 1'b1;
    while (!done && edges < 40) begin step(); edges++; end
    chk("freeze latency", 64'(edges), 64'd12);
    chk("freeze p", p, ref_pool(r1));
    start = 1'b0;
    step();
    chk("freeze done drop", {63'd0, done}, 64'd0);

    // Reset at window 4 aborts the run.
    for (int k = 0; k < 8; k++) r2[k*32 +: 32] = $urandom() | 32'h01010101;
    y_in = r2; start = 1'b1;
    repeat (5) step();
    rst = 1'b1; start = 1'b0;
    step();
    chk("abort p", p, 64'd0);
    chk("abort done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    step();
    run("rerun", r2, ref_pool(r2));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
